// File: rtl/demux_1x2_32bits.sv
// demux_1x2_32bits
// Registered 1-to-2 demultiplexer with valid/ready handshakes. Each input word
// is steered by its sel bit into one of two single-entry output buffers (A/B),
// so a stalled consumer only blocks words that are headed for it.
//
// Optional feature: define DEMUX_STATS_EN to add saturating 16-bit
// delivered-word counters (A_count / B_count).
//
// Buffer FSM (one per output):
//   state | meaning
//   EMPTY | buffer holds no word, X_valid = 0
//   FULL  | buffer holds a word,  X_valid = 1, data held until taken
module demux_1x2_32bits #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] IN,
    output logic             A_valid,
    input  logic             A_ready,
    output logic [WIDTH-1:0] A,
    output logic             B_valid,
    input  logic             B_ready,
    output logic [WIDTH-1:0] B
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      A_count,
    output logic [15:0]      B_count
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state_a, state_a_nxt;
    logic [0:0] state_b, state_b_nxt;
    logic       in_xfer;
    logic       load_a, load_b;
    logic       out_a, out_b;

    assign A_valid = (state_a == FULL);
    assign B_valid = (state_b == FULL);

    // A destination can take a word when empty or when it is being drained
    // this cycle; deliberately independent of in_valid.
    always_comb begin
        in_ready = sel ? (!B_valid || B_ready) : (!A_valid || A_ready);
    end

    assign in_xfer = in_valid && in_ready;
    assign load_a  = in_xfer && !sel;
    assign load_b  = in_xfer &&  sel;
    assign out_a   = A_valid && A_ready;
    assign out_b   = B_valid && B_ready;

    // Next-state logic for buffer A; a reload while draining stays FULL.
    always_comb begin
        state_a_nxt = state_a;
        case (state_a)
            EMPTY:   if (load_a) state_a_nxt = FULL;
            FULL:    if (out_a && !load_a) state_a_nxt = EMPTY;
            default: state_a_nxt = EMPTY;
        endcase
    end

    // Next-state logic for buffer B.
    always_comb begin
        state_b_nxt = state_b;
        case (state_b)
            EMPTY:   if (load_b) state_b_nxt = FULL;
            FULL:    if (out_b && !load_b) state_b_nxt = EMPTY;
            default: state_b_nxt = EMPTY;
        endcase
    end

    // State registers; reset discards anything held or in flight.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_a <= EMPTY;
            state_b <= EMPTY;
        end else begin
            state_a <= state_a_nxt;
            state_b <= state_b_nxt;
        end
    end

    // Data registers load on an input transfer to their buffer, else hold.
    always_ff @(posedge Clk) begin
        if (reset) begin
            A <= '0;
            B <= '0;
        end else begin
            if (load_a) A <= IN;
            if (load_b) B <= IN;
        end
    end

`ifdef DEMUX_STATS_EN
    // Saturating delivered-word counters, one per output.
    always_ff @(posedge Clk) begin
        if (reset) begin
            A_count <= '0;
            B_count <= '0;
        end else begin
            if (out_a && (A_count != 16'hFFFF)) A_count <= A_count + 16'd1;
            if (out_b && (B_count != 16'hFFFF)) B_count <= B_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_32bits.sv
// Testbench for demux_1x2_32bits: directed scenarios plus random traffic,
// checked by a queue-based scoreboard. Each output buffer is modelled as a
// queue of at most one word.
module tb_demux_1x2_32bits;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] IN = '0;
    logic        A_ready = 1'b0;
    logic        B_ready = 1'b0;
    logic        in_ready, A_valid, B_valid;
    logic [31:0] A, B;
`ifdef DEMUX_STATS_EN
    logic [15:0] A_count, B_count;
`endif

    always #5 Clk = ~Clk;

    demux_1x2_32bits dut (
        .Clk      (Clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .IN       (IN),
        .A_valid  (A_valid),
        .A_ready  (A_ready),
        .A        (A),
        .B_valid  (B_valid),
        .B_ready  (B_ready),
        .B        (B)
`ifdef DEMUX_STATS_EN
        ,
        .A_count  (A_count),
        .B_count  (B_count)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          cnt_a = 0;
    int          cnt_b = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the expected word is queued on acceptance.
    task automatic step(input logic rst, input logic iv, input logic s,
                        input logic [31:0] d, input logic ar, input logic br);
        logic exp_rdy;
        logic acc;
        @(negedge Clk);
        reset = rst; in_valid = iv; sel = s; IN = d; A_ready = ar; B_ready = br;
        #1;
        exp_rdy = s ? (q_b.size() == 0 || br) : (q_a.size() == 0 || ar);
        if (mon_en) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = iv && exp_rdy && !rst;
        @(posedge Clk);
        if (rst) begin
            q_a.delete(); q_b.delete();
            cnt_a = 0; cnt_b = 0;
            #1;
            check("A_after_reset", A, 32'd0);
            check("B_after_reset", B, 32'd0);
            check("A_valid_after_reset", {31'd0, A_valid}, 32'd0);
            check("B_valid_after_reset", {31'd0, B_valid}, 32'd0);
            mon_en = 1'b1;
        end else if (acc) begin
            if (s) q_b.push_back(d);
            else   q_a.push_back(d);
        end
    endtask

    // Monitor: compares presented outputs against the queues, retires on transfer.
    always begin
        @(negedge Clk);
        #2;
        if (mon_en) begin
            check("A_valid", {31'd0, A_valid}, {31'd0, q_a.size() != 0});
            check("B_valid", {31'd0, B_valid}, {31'd0, q_b.size() != 0});
            if (A_valid && q_a.size() != 0) check("A_data", A, q_a[0]);
            if (B_valid && q_b.size() != 0) check("B_data", B, q_b[0]);
`ifdef DEMUX_STATS_EN
            check("A_count", {16'd0, A_count}, cnt_a);
            check("B_count", {16'd0, B_count}, cnt_b);
`endif
            if (!reset && A_valid && A_ready && q_a.size() != 0) begin
                void'(q_a.pop_front());
                if (cnt_a < 65535) cnt_a++;
            end
            if (!reset && B_valid && B_ready && q_b.size() != 0) begin
                void'(q_b.pop_front());
                if (cnt_b < 65535) cnt_b++;
            end
        end
    end

    initial begin
        step(1, 0, 0, 32'd0, 0, 0);
        step(1, 1, 1, 32'hFFFF_FFFF, 1, 1);

        // single write to A, held while A_ready = 0
        step(0, 1, 0, 32'hDEADBEEF, 0, 0);
        step(0, 0, 0, 32'd0, 0, 0);
        step(0, 0, 1, 32'd0, 0, 0);

        // backpressure isolation: A stalled, B still accepts
        step(0, 1, 0, 32'h1111_1111, 0, 0);
        step(0, 1, 1, 32'h0000_0005, 0, 0);
        step(0, 0, 0, 32'd0, 0, 0);

        // drain both simultaneously
        step(0, 0, 0, 32'd0, 1, 1);
        step(0, 0, 0, 32'd0, 1, 1);

        // streaming into A with no bubbles
        for (int i = 1; i <= 4; i++) step(0, 1, 0, i, 1, 0);
        step(0, 0, 0, 32'd0, 1, 0);
        step(0, 0, 0, 32'd0, 1, 0);

        // reset mid-operation with a word in flight
        step(0, 1, 0, 32'h0000_1234, 0, 0);
        step(1, 1, 1, 32'hCAFE_F00D, 0, 0);
        step(0, 0, 0, 32'd0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 1));

`ifdef DEMUX_STATS_EN
        step(1, 0, 0, 32'd0, 0, 0);
        for (int i = 0; i < 70001; i++) step(0, 1, 0, i, 1, 0);
        step(0, 0, 0, 32'd0, 1, 0);
        step(0, 0, 0, 32'd0, 0, 0);
        check("A_count_sat", {16'd0, A_count}, 32'h0000_FFFF);
        check("B_count_idle", {16'd0, B_count}, 32'd0);
        step(1, 0, 0, 32'd0, 0, 0);
        step(0, 0, 0, 32'd0, 0, 0);
        check("A_count_reset", {16'd0, A_count}, 32'd0);
`endif

        step(0, 0, 0, 32'd0, 1, 1);
        step(0, 0, 0, 32'd0, 1, 1);
        @(negedge Clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
